// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam logic [3:0]  OP_SPECIAL   = 4'h0;
    localparam logic [3:0]  FUNC_NOTHING = 4'hF;

    // Harmless no-op that decode treats as "nothing to do".
    localparam logic [31:0] BUBBLE_INST  = {OP_SPECIAL, 24'b0, FUNC_NOTHING};

    typedef enum logic [1:0] {
        F_IDLE,
        F_RUN,
        F_WAIT,
        F_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction BRAM
// and hands one {pc, inst} pair per cycle to decode (static predict-not-taken).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IMEM_AW  = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    input  logic               dec_jump,
    input  logic               dec_is_jr,
    input  logic [31:0]        dec_npc,
    input  logic               dec_stop,
    input  logic [4:0]         dec_wait_time,
    input  logic               ex_redirect,
    input  logic [31:0]        ex_target,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    fetch_state_t state;
    logic [31:0]  fpc;
    logic         live;
    logic [4:0]   cnt;
    logic [31:0]  next_fpc;
    logic         deliver;

    // A taken branch in execute kills whatever is sitting in fetch this cycle.
    assign deliver   = (state == F_RUN) && live && !ex_redirect;
    assign inst      = deliver ? imem_rdata : BUBBLE_INST;
    assign pc        = fpc;
    assign halted    = (state == F_HALT);
    assign imem_addr = next_fpc[IMEM_AW+1:2];

    always_comb begin
        next_fpc = fpc;
        case (state)
            F_IDLE: next_fpc = RESET_PC;
            F_RUN: begin
                if (ex_redirect)
                    next_fpc = ex_target;
                else if (live && dec_stop)
                    next_fpc = fpc;
                else if (live && (dec_jump || dec_is_jr))
                    next_fpc = dec_npc;
                else
                    next_fpc = fpc + 32'd4;
            end
            F_WAIT: begin
                if (ex_redirect)
                    next_fpc = ex_target;
            end
            default: next_fpc = fpc;
        endcase
    end

    // WAIT keeps re-reading the same word so it is on the bus when RUN resumes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= F_IDLE;
            fpc         <= RESET_PC;
            live        <= 1'b0;
            cnt         <= 5'd0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (start) begin
                        fpc   <= RESET_PC;
                        live  <= 1'b1;
                        state <= F_RUN;
                    end
                end
                F_RUN: begin
                    fpc  <= next_fpc;
                    live <= 1'b1;
                    if (deliver)
                        fetch_count <= fetch_count + 32'd1;
                    if (deliver && dec_stop) begin
                        state <= F_HALT;
                    end else if (deliver && (dec_wait_time != 5'd0)) begin
                        cnt   <= dec_wait_time;
                        state <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    fpc <= next_fpc;
                    if (ex_redirect) begin
                        cnt   <= 5'd0;
                        state <= F_RUN;
                    end else begin
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1)
                            state <= F_RUN;
                    end
                end
                default: begin
                    state <= F_HALT;
                end
            endcase
        end
    end

endmodule
